// File: rtl/rom_prog_ctrl.sv
// rom_prog_ctrl: shares ROM port 2 between core data reads and a byte-stream programming loader.
// Optional running checksum of written words when ROM_PROG_CHECKSUM_EN is defined.
`ifndef DEFAULT_ROM_ADDR_WIDTH
`define DEFAULT_ROM_ADDR_WIDTH 10
`endif

module rom_prog_ctrl #(
   parameter int ADDR_WIDTH = `DEFAULT_ROM_ADDR_WIDTH,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_rd_en,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [31:0]           cpu_rd_data,
   output logic                  cpu_hold,
   input  logic                  prog_start,
   input  logic                  prog_valid,
   output logic                  prog_ready,
   input  logic [7:0]            prog_byte,
   input  logic                  prog_last,
   output logic                  prog_busy,
   output logic                  prog_done,
   output logic                  prog_error,
   output logic                  rom_rd_en2,
   output logic                  rom_wr_en2,
   output logic [ADDR_WIDTH-1:0] rom_addr2,
   output logic [31:0]           rom_wr_data2,
   output logic [3:0]            rom_wr_strobe2,
   input  logic [31:0]           rom_rd_data2
`ifdef ROM_PROG_CHECKSUM_EN
   ,
   output logic [31:0]           prog_checksum
`endif
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           word_buf;
   logic [3:0]            lanes;
   logic [1:0]            byte_cnt;
   logic                  last_seen, idle, accept, wr_cyc;

   assign idle   = state == IDLE;
   assign accept = (state == LOAD) && prog_valid;
   assign wr_cyc = state == WRITE;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = prog_start ? LOAD : IDLE;
         LOAD:    state_nx = (accept && (prog_last || byte_cnt == 2'd3)) ? WRITE : LOAD;
         WRITE:   state_nx = last_seen ? DONE : LOAD;
         default: state_nx = IDLE;
      endcase
   end

   // The core owns the port only while idle; otherwise the loader's address is driven.
   assign rom_rd_en2     = idle & cpu_rd_en;
   assign rom_addr2      = idle ? cpu_addr : wr_addr;
   assign cpu_rd_data    = idle ? rom_rd_data2 : 32'd0;
   assign cpu_hold       = ~idle;
   assign prog_busy      = ~idle;
   assign prog_ready     = state == LOAD;
   assign prog_done      = state == DONE;
   assign rom_wr_en2     = wr_cyc & ~prog_error;
   assign rom_wr_data2   = wr_cyc ? word_buf : 32'd0;
   assign rom_wr_strobe2 = wr_cyc ? lanes : 4'd0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_addr    <= '0;
         word_buf   <= '0;
         lanes      <= '0;
         byte_cnt   <= '0;
         last_seen  <= 1'b0;
         prog_error <= 1'b0;
      end else if (idle) begin
         if (prog_start) begin
            wr_addr    <= BASE;
            word_buf   <= '0;
            lanes      <= '0;
            byte_cnt   <= '0;
            last_seen  <= 1'b0;
            prog_error <= 1'b0;
         end
      end else if (accept) begin
         word_buf[{byte_cnt, 3'b000} +: 8] <= prog_byte;
         lanes[byte_cnt]                   <= 1'b1;
         byte_cnt                          <= byte_cnt + 2'd1;
         if (prog_last) last_seen <= 1'b1;
      end else if (wr_cyc) begin
         wr_addr  <= wr_addr + 1'b1;
         word_buf <= '0;
         lanes    <= '0;
         byte_cnt <= '0;
         // Writing the top word wraps the address: everything after it is dropped.
         if (&wr_addr) prog_error <= 1'b1;
      end

`ifdef ROM_PROG_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst)
      if (rst)                    prog_checksum <= '0;
      else if (idle && prog_start) prog_checksum <= '0;
      else if (wr_cyc)            prog_checksum <= prog_checksum + word_buf;
`endif
endmodule

// File: tb/tb_rom_prog_ctrl.sv
// tb_rom_prog_ctrl: randomized self-checking bench for rom_prog_ctrl against an image-level model.
module tb_rom_prog_ctrl;
   localparam int AW    = 3;
   localparam int BASE  = 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 0, rst = 1, cpu_rd_en = 0;
   logic [AW-1:0] cpu_addr = '0;
   logic [31:0]   cpu_rd_data;
   logic          cpu_hold;
   logic          prog_start = 0, prog_valid = 0, prog_last = 0;
   logic [7:0]    prog_byte = '0;
   logic          prog_ready, prog_busy, prog_done, prog_error;
   logic          rom_rd_en2, rom_wr_en2;
   logic [AW-1:0] rom_addr2;
   logic [31:0]   rom_wr_data2, rom_rd_data2;
   logic [3:0]    rom_wr_strobe2;
`ifdef ROM_PROG_CHECKSUM_EN
   logic [31:0]   prog_checksum;
`endif

   typedef struct {int a; logic [31:0] d; logic [3:0] s;} wr_t;
   logic [31:0] rom [DEPTH];
   logic [31:0] exp_rom [DEPTH];
   logic        init_rom = 1;
   wr_t         obs_wr[$];
   int          done_cnt = 0;
   int          errors = 0, checks = 0;

   rom_prog_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .cpu_rd_en(cpu_rd_en), .cpu_addr(cpu_addr),
      .cpu_rd_data(cpu_rd_data), .cpu_hold(cpu_hold), .prog_start(prog_start),
      .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_byte(prog_byte),
      .prog_last(prog_last), .prog_busy(prog_busy), .prog_done(prog_done),
      .prog_error(prog_error), .rom_rd_en2(rom_rd_en2), .rom_wr_en2(rom_wr_en2),
      .rom_addr2(rom_addr2), .rom_wr_data2(rom_wr_data2),
      .rom_wr_strobe2(rom_wr_strobe2), .rom_rd_data2(rom_rd_data2)
`ifdef ROM_PROG_CHECKSUM_EN
      , .prog_checksum(prog_checksum)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 5) ? 32'hDEADBEEF : (32'h5A5A0000 ^ (32'h01010101 * 32'(i)));
   endfunction

   assign rom_rd_data2 = rom[rom_addr2];

   always @(posedge clk) begin
      if (init_rom) for (int i = 0; i < DEPTH; i++) rom[i] <= init_word(i);
      else if (rom_wr_en2)
         for (int b = 0; b < 4; b++)
            if (rom_wr_strobe2[b]) rom[rom_addr2][8*b +: 8] <= rom_wr_data2[8*b +: 8];
   end

   always @(negedge clk) begin
      if (rom_wr_en2) obs_wr.push_back('{int'(rom_addr2), rom_wr_data2, rom_wr_strobe2});
      if (prog_done) done_cnt++;
   end

   task automatic test_reset();
      rst = 1;
      prog_valid = 1;
      #1;
      checks++;
      if ({prog_ready, prog_busy, prog_done, prog_error, rom_wr_en2, cpu_hold} !== 6'b0 ||
          rom_wr_strobe2 !== 4'd0 || rom_wr_data2 !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b err=%b wr=%b hold=%b stb=%h data=%h, want all 0",
                  prog_ready, prog_busy, prog_done, prog_error, rom_wr_en2, cpu_hold, rom_wr_strobe2, rom_wr_data2);
      end
`ifdef ROM_PROG_CHECKSUM_EN
      checks++;
      if (prog_checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum: got %h want 0", prog_checksum); end
`endif
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++;
      if (prog_ready !== 1'b0) begin errors++; $display("FAIL idle_not_ready: got %b want 0", prog_ready); end
      prog_valid = 0;
   endtask

   task automatic read_check(input int a, input string tag);
      cpu_rd_en = 1;
      cpu_addr  = AW'(a);
      #1;
      checks++;
      if (cpu_rd_data !== exp_rom[a] || rom_rd_en2 !== 1'b1 || rom_addr2 !== AW'(a) ||
          rom_wr_en2 !== 1'b0 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL %s addr %0d: got data=%h rd=%b addr=%0d wr=%b hold=%b, want data=%h rd=1 wr=0 hold=0",
                  tag, a, cpu_rd_data, rom_rd_en2, rom_addr2, rom_wr_en2, cpu_hold, exp_rom[a]);
      end
   endtask

   task automatic test_passthrough();
      read_check(5, "passthrough");
      for (int k = 0; k < 4; k++) read_check(int'($urandom_range(DEPTH - 1)), "passthrough");
      cpu_rd_en = 0;
      #1;
      checks++;
      if (rom_rd_en2 !== 1'b0) begin errors++; $display("FAIL idle_rd_en_off: got %b want 0", rom_rd_en2); end
   endtask

   task automatic send_image(input logic [7:0] img[$], input int gap_pct, input bit noise);
      int          n = img.size();
      int          nwords = (n + 3) / 4;
      int          i = 0, cyc = 0, wr0, d0;
      bit          acc, seen;
      logic [31:0] sum, w;
      logic [3:0]  s;
      bit          exp_err;
      wr_t         exp_q[$];
      sum = '0;
      for (int k = 0; k < nwords; k++) begin
         w = '0;
         s = '0;
         for (int b = 0; b < 4; b++)
            if (4*k + b < n) begin w[8*b +: 8] = img[4*k + b]; s[b] = 1'b1; end
         sum += w;
         if (BASE + k < DEPTH) begin
            exp_q.push_back('{BASE + k, w, s});
            for (int b = 0; b < 4; b++) if (s[b]) exp_rom[BASE + k][8*b +: 8] = w[8*b +: 8];
         end
      end
      exp_err = (BASE + nwords >= DEPTH);
      wr0 = obs_wr.size();
      d0  = done_cnt;
      @(posedge clk); #1 prog_start = 1;
      @(posedge clk); #1 prog_start = 0;
      @(negedge clk);
      checks++;
      if (prog_error !== 1'b0 || prog_busy !== 1'b1 || prog_ready !== 1'b1) begin
         errors++;
         $display("FAIL session_start: got err=%b busy=%b rdy=%b want 0 1 1", prog_error, prog_busy, prog_ready);
      end
      @(posedge clk); #1;
      while (i < n && cyc < 4000) begin
         prog_valid = ($urandom_range(99) >= gap_pct);
         prog_byte  = img[i];
         prog_last  = (i == n - 1);
         if (noise) begin
            prog_start = ($urandom_range(3) == 0);
            cpu_rd_en  = 1'($urandom_range(1));
            cpu_addr   = AW'($urandom_range(DEPTH - 1));
         end
         @(negedge clk);
         checks++;
         if (cpu_hold !== 1'b1 || rom_rd_en2 !== 1'b0 || cpu_rd_data !== 32'd0) begin
            errors++;
            $display("FAIL core_held: got hold=%b rd=%b data=%h want 1 0 0", cpu_hold, rom_rd_en2, cpu_rd_data);
         end
         acc = prog_valid && prog_ready;
         @(posedge clk); #1;
         if (acc) i++;
         cyc++;
      end
      prog_valid = 0; prog_last = 0; prog_start = 0;
      checks++;
      if (cyc >= 4000) begin errors++; $display("FAIL byte_timeout: accepted %0d of %0d", i, n); end
      if (gap_pct == 0) begin
         checks++;
         if (cyc != n + (n - 1) / 4) begin
            errors++;
            $display("FAIL throughput: got %0d cycles want %0d", cyc, n + (n - 1) / 4);
         end
      end
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 10) begin @(negedge clk); seen = prog_done; cyc++; end
      checks++;
      if (!seen || cyc != 2) begin errors++; $display("FAIL done_latency: got seen=%b after %0d want 2", seen, cyc); end
      checks++;
      if (prog_error !== exp_err) begin errors++; $display("FAIL prog_error: got %b want %b", prog_error, exp_err); end
`ifdef ROM_PROG_CHECKSUM_EN
      checks++;
      if (prog_checksum !== sum) begin errors++; $display("FAIL checksum: got %h want %h", prog_checksum, sum); end
`endif
      @(posedge clk); #1;
      read_check(int'($urandom_range(DEPTH - 1)), "resume_read");
      checks++;
      if (prog_busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", prog_busy); end
      cpu_rd_en = 0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulses: got %0d want 1", done_cnt - d0); end
      checks++;
      if (obs_wr.size() - wr0 != exp_q.size()) begin
         errors++;
         $display("FAIL write_count: got %0d want %0d", obs_wr.size() - wr0, exp_q.size());
      end else
         foreach (exp_q[j]) begin
            checks++;
            if (obs_wr[wr0 + j].a != exp_q[j].a || obs_wr[wr0 + j].d !== exp_q[j].d || obs_wr[wr0 + j].s !== exp_q[j].s) begin
               errors++;
               $display("FAIL write%0d: got a=%0d d=%h s=%b want a=%0d d=%h s=%b", j, obs_wr[wr0 + j].a,
                        obs_wr[wr0 + j].d, obs_wr[wr0 + j].s, exp_q[j].a, exp_q[j].d, exp_q[j].s);
            end
         end
   endtask

   task automatic test_full_words();
      logic [7:0] img[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_image(img, 0, 0);
   endtask

   task automatic test_partial();
      logic [7:0] img[$] = '{8'hAA, 8'hBB, 8'hCC};
      send_image(img, 0, 0);
   endtask

   task automatic test_single_byte();
      logic [7:0] img[$] = '{8'h5C};
      send_image(img, 0, 1);
   endtask

   task automatic test_random();
      logic [7:0] img[$];
      for (int t = 0; t < 6; t++) begin
         img.delete();
         for (int k = 0; k < int'($urandom_range(1, 20)); k++) img.push_back(8'($urandom));
         send_image(img, (t % 2) ? 30 : 0, t >= 3);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] img[$];
      for (int k = 0; k < 36; k++) img.push_back(8'($urandom));
      send_image(img, 20, 1);
   endtask

   task automatic test_reset_mid();
      int          wr0 = obs_wr.size();
      logic [7:0]  img[$];
      @(posedge clk); #1 prog_start = 1;
      @(posedge clk); #1 prog_start = 0; prog_valid = 1; prog_byte = 8'h12;
      @(posedge clk); #1 prog_byte = 8'h34;
      @(posedge clk); #1 prog_valid = 0;
      #2 rst = 1;
      #1;
      checks++;
      if ({prog_ready, prog_busy, prog_done, prog_error, rom_wr_en2, cpu_hold} !== 6'b0 ||
          rom_wr_strobe2 !== 4'd0 || rom_wr_data2 !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: got rdy=%b busy=%b done=%b err=%b wr=%b hold=%b stb=%h data=%h, want all 0",
                  prog_ready, prog_busy, prog_done, prog_error, rom_wr_en2, cpu_hold, rom_wr_strobe2, rom_wr_data2);
      end
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++;
      if (obs_wr.size() != wr0) begin errors++; $display("FAIL reset_no_write: got %0d writes want 0", obs_wr.size() - wr0); end
      for (int k = 0; k < 6; k++) img.push_back(8'($urandom));
      send_image(img, 0, 0);
   endtask

   task automatic test_rom_contents();
      for (int a = 0; a < DEPTH; a++) begin
         @(negedge clk);
         read_check(a, "rom_contents");
      end
      cpu_rd_en = 0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) exp_rom[i] = init_word(i);
      @(posedge clk); #1 init_rom = 0;
      test_reset();
      test_passthrough();
      test_full_words();
      test_partial();
      test_single_byte();
      test_random();
      test_overflow();
      test_reset_mid();
      test_rom_contents();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
